ann_layer_sequencer: RTL and testbench
======================================

Name: ann_layer_sequencer

Overview:
- Sequences one shared multiply-accumulate/activation datapath through the full drowsiness-detector ANN: 30 inputs → 5 hidden neurons → 3 output neurons.
- Generates weight addresses, operand selects, accumulator control and result write strobes.
- In train mode, appends a weight-update sweep after each forward pass and repeats for EPOCHS passes.
- Sits between the top-level Start/train controls and the ANN datapath/weight store.

Parameters:
- N_IN, 30, inputs per hidden neuron
- N_HID, 5, hidden neurons (also operands per output neuron)
- N_OUT, 3, output neurons
- ADDR_W, 8, weight address width; must satisfy 2^ADDR_W ≥ N_IN*N_HID + N_HID*N_OUT (165)
- EPOCHS, 100, forward+update passes per training run (≥1)
- EP_W, 10, epoch counter width

Ports:
- Clock  in  1  system clock
- Rst  in  1  synchronous active-high reset
- Start  in  1  level; sampled only in IDLE
- train  in  1  mode select, latched when Start is accepted
- mac_ready  in  1  datapath accepts the current operand
- act_done  in  1  activation result is valid
- upd_ready  in  1  weight store accepts the update at w_addr
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- done_train  out  1  sticky after a training run; cleared on the next accepted Start
- state  out  4  current FSM state (debug LEDs)
- w_addr  out  ADDR_W  weight address (MAC and UPD)
- in_sel  out  5  operand index: input i (hidden layer) or hidden j (output layer)
- layer  out  1  0 = hidden, 1 = output
- neuron_idx  out  3  neuron under computation / being written
- acc_clr  out  1  clear accumulator
- mac_valid  out  1  operand/weight valid
- mac_last  out  1  with mac_valid: last operand of the neuron
- act_req  out  1  level; held until act_done
- res_wr  out  1  write activation result for (layer, neuron_idx)
- upd_en  out  1  update-sweep request at w_addr
- epoch_cnt  out  EP_W  completed-pass index of the current run

Behaviour:
- Reset: state = IDLE; every output 0; train latch 0; all counters 0. Rst has priority over every other input, including Start in the same cycle, and aborts any run with no done pulse.
- IDLE:
  - If Start = 1: latch train, clear epoch_cnt and done_train, go to CLR with layer = 0, neuron_idx = 0.
  - Start while busy is ignored.
- CLR (1 cycle): acc_clr = 1; in_sel = 0. Next state: MAC.
- MAC:
  - mac_valid = 1.
  - w_addr = neuron_idx*N_IN + in_sel for the hidden layer; N_IN*N_HID + neuron_idx*N_HID + in_sel for the output layer.
  - mac_last = 1 when in_sel = (layer ? N_HID : N_IN) − 1.
  - in_sel increments only when mac_valid && mac_ready. A handshake on the last operand moves to ACT.
- ACT:
  - act_req = 1 until act_done is sampled high.
  - In the act_done cycle: res_wr = 1 and the FSM advances.
    - If more neurons remain in the layer: neuron_idx+1 → CLR.
    - Else if hidden layer: layer = 1, neuron_idx = 0 → CLR.
    - Else: UPD if train, otherwise DONE.
- UPD:
  - upd_en = 1, w_addr starting at 0.
  - w_addr increments on upd_en && upd_ready.
  - Handshake at address 164 (last weight):
    - If epoch_cnt = EPOCHS−1: done_train = 1 → DONE.
    - Otherwise: epoch_cnt+1, layer = 0, neuron_idx = 0 → CLR.
- DONE (1 cycle): done = 1 → IDLE. done_train holds.
- Latency, with mac_ready and act_done tied high and Start accepted in cycle 0:
  - Hidden neuron = 1 + 30 + 1 = 32 cycles; output neuron = 1 + 5 + 1 = 7 cycles.
  - Inference: done in cycle 182.
  - Training: each pass = 181 + 165 cycles.
- Outputs are registered (Moore). w_addr/in_sel are held stable while mac_ready or upd_ready is low.

Decomposition:
- Package ann_seq_pkg:
  - state enum: IDLE = 0, CLR = 1, MAC = 2, ACT = 3, UPD = 4, DONE = 5; 4-bit encoding.
  - Constants: N_WEIGHTS = N_IN*N_HID + N_HID*N_OUT, OUT_BASE = N_IN*N_HID.
- One sub-module, ann_idx_counter: nested neuron/operand counter with enable, clear and a programmable inner limit, reused for the hidden and output layers.

Test Plan:
- Inference, ready signals tied high:
  - Start in cycle 0 → done in cycle 182.
  - Exactly 8 res_wr pulses: hidden neurons 0–4, then output neurons 0–2.
  - w_addr sequence runs 0..149, then 150..164; upd_en never high.
- MAC backpressure: mac_ready low on every other cycle → w_addr/in_sel are held while stalled; the sequence is identical, just slower; mac_last coincides with addresses 29, 59, …, 149 and 154, 159, 164.
- Training, EPOCHS = 2, all ready signals high:
  - Two full forward passes, each followed by 165 upd_en cycles (addresses 0–164).
  - epoch_cnt goes 0→1; done_train rises in the done cycle and stays high.
  - A subsequent Start clears done_train.
- Start re-asserted mid-run → ignored, no restart. Start and Rst high in the same cycle → remains IDLE, all outputs 0.
- Rst during UPD of epoch 1 → IDLE next cycle; no done pulse; epoch_cnt = 0.
- act_done delayed 5 cycles → act_req held for 5 cycles; res_wr is a single pulse in the act_done cycle.

Source files
------------

// File: rtl/ann_seq_pkg.sv
// Shared constants, state encoding and address helpers for the ANN layer sequencer.
package ann_seq_pkg;

    localparam int unsigned N_IN       = 30;
    localparam int unsigned N_HID      = 5;
    localparam int unsigned N_OUT      = 3;
    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned EPOCHS_DEF = 100;
    localparam int unsigned EP_W_DEF   = 10;

    localparam int unsigned SEL_W  = 5;
    localparam int unsigned NIDX_W = 3;
    localparam int unsigned ST_W   = 4;

    localparam int unsigned OUT_BASE  = N_IN * N_HID;
    localparam int unsigned N_WEIGHTS = OUT_BASE + N_HID * N_OUT;

    typedef enum logic [ST_W-1:0] {
        IDLE = 4'd0,
        CLR  = 4'd1,
        MAC  = 4'd2,
        ACT  = 4'd3,
        UPD  = 4'd4,
        DONE = 4'd5
    } state_t;

    // Index of the last operand of a neuron in the given layer.
    function automatic logic [SEL_W-1:0] last_sel(input logic lay);
        return lay ? SEL_W'(N_HID - 1) : SEL_W'(N_IN - 1);
    endfunction

    // Weight address: hidden weights first, output-layer weights after them.
    function automatic logic [ADDR_W-1:0] mac_addr(input logic              lay,
                                                   input logic [NIDX_W-1:0] nidx,
                                                   input logic [SEL_W-1:0]  sel);
        int unsigned base;
        base = lay ? OUT_BASE + 32'(nidx) * N_HID : 32'(nidx) * N_IN;
        return ADDR_W'(base + 32'(sel));
    endfunction

endpackage

// File: rtl/ann_idx_counter.sv
// Nested neuron/operand counter; exposes next values so the caller can register derived outputs.
module ann_idx_counter #(
    parameter int unsigned SEL_W  = 5,
    parameter int unsigned NIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inner_en,
    input  logic              outer_inc,
    input  logic [SEL_W-1:0]  inner_limit,
    output logic [SEL_W-1:0]  inner,
    output logic [NIDX_W-1:0] outer,
    output logic              inner_last_c,
    output logic [SEL_W-1:0]  inner_nxt_c,
    output logic [NIDX_W-1:0] outer_nxt_c
);

    assign inner_last_c = (inner == inner_limit);

    always_comb begin
        inner_nxt_c = inner;
        outer_nxt_c = outer;
        if (clr) begin
            inner_nxt_c = '0;
            outer_nxt_c = '0;
        end else if (outer_inc) begin
            outer_nxt_c = outer + 1'b1;
            inner_nxt_c = '0;
        end else if (inner_en && !inner_last_c) begin
            inner_nxt_c = inner + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inner <= '0;
            outer <= '0;
        end else begin
            inner <= inner_nxt_c;
            outer <= outer_nxt_c;
        end
    end

endmodule

// File: rtl/ann_layer_sequencer.sv
// Drives the shared MAC/activation datapath through the 30-5-3 ANN forward pass,
// optionally followed by a weight-update sweep for a fixed number of epochs.
module ann_layer_sequencer
    import ann_seq_pkg::*;
#(
    parameter int unsigned EPOCHS = EPOCHS_DEF,
    parameter int unsigned EP_W   = EP_W_DEF
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              Start,
    input  logic              train,
    input  logic              mac_ready,
    input  logic              act_done,
    input  logic              upd_ready,
    output logic              busy,
    output logic              done,
    output logic              done_train,
    output logic [ST_W-1:0]   state,
    output logic [ADDR_W-1:0] w_addr,
    output logic [SEL_W-1:0]  in_sel,
    output logic              layer,
    output logic [NIDX_W-1:0] neuron_idx,
    output logic              acc_clr,
    output logic              mac_valid,
    output logic              mac_last,
    output logic              act_req,
    output logic              res_wr,
    output logic              upd_en,
    output logic [EP_W-1:0]   epoch_cnt
);

    state_t             state_q, state_d;
    logic               train_q, train_d;
    logic               layer_d;
    logic [EP_W-1:0]    epoch_d;
    logic               done_train_d;
    logic               cnt_clr, cnt_inc, cnt_next;
    logic               sel_last;
    logic [SEL_W-1:0]   sel_d;
    logic [NIDX_W-1:0]  nidx_d;
    logic [ADDR_W-1:0]  upd_addr, w_addr_d;
    logic               mac_hs, upd_hs;
    logic               busy_d, done_d, acc_clr_d, mac_valid_d, mac_last_d, act_req_d, upd_en_d;

    ann_idx_counter #(
        .SEL_W  (SEL_W),
        .NIDX_W (NIDX_W)
    ) u_idx (
        .clk          (Clock),
        .rst          (Rst),
        .clr          (cnt_clr),
        .inner_en     (cnt_inc),
        .outer_inc    (cnt_next),
        .inner_limit  (last_sel(layer)),
        .inner        (in_sel),
        .outer        (neuron_idx),
        .inner_last_c (sel_last),
        .inner_nxt_c  (sel_d),
        .outer_nxt_c  (nidx_d)
    );

    assign state = state_q;
    // Strobe must coincide with act_done so it is tagged with the neuron just finished.
    assign res_wr = act_req && act_done;

    always_comb begin
        state_d      = state_q;
        train_d      = train_q;
        layer_d      = layer;
        epoch_d      = epoch_cnt;
        done_train_d = done_train;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        cnt_next     = 1'b0;
        upd_addr     = (state_q == UPD) ? w_addr : '0;
        mac_hs       = mac_valid && mac_ready;
        upd_hs       = upd_en && upd_ready;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    train_d      = train;
                    epoch_d      = '0;
                    done_train_d = 1'b0;
                    layer_d      = 1'b0;
                    cnt_clr      = 1'b1;
                    state_d      = CLR;
                end
            end
            CLR: state_d = MAC;
            MAC: begin
                if (mac_hs) begin
                    if (sel_last) state_d = ACT;
                    else          cnt_inc = 1'b1;
                end
            end
            ACT: begin
                if (act_done) begin
                    if (32'(neuron_idx) != (layer ? N_OUT : N_HID) - 1) begin
                        cnt_next = 1'b1;
                        state_d  = CLR;
                    end else if (!layer) begin
                        layer_d = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = CLR;
                    end else if (train_q) begin
                        state_d = UPD;
                    end else begin
                        layer_d = 1'b0;
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            UPD: begin
                if (upd_hs) begin
                    if (32'(w_addr) == N_WEIGHTS - 1) begin
                        layer_d = 1'b0;
                        cnt_clr = 1'b1;
                        if (32'(epoch_cnt) == EPOCHS - 1) begin
                            done_train_d = 1'b1;
                            state_d      = DONE;
                        end else begin
                            epoch_d = epoch_cnt + 1'b1;
                            state_d = CLR;
                        end
                    end else begin
                        upd_addr = w_addr + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Moore outputs decoded from the next state so they register alongside it.
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        acc_clr_d   = (state_d == CLR);
        mac_valid_d = (state_d == MAC);
        act_req_d   = (state_d == ACT);
        upd_en_d    = (state_d == UPD);
        mac_last_d  = (state_d == MAC) && (sel_d == last_sel(layer_d));
        case (state_d)
            MAC:     w_addr_d = mac_addr(layer_d, nidx_d, sel_d);
            UPD:     w_addr_d = upd_addr;
            default: w_addr_d = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            train_q    <= 1'b0;
            layer      <= 1'b0;
            epoch_cnt  <= '0;
            done_train <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            acc_clr    <= 1'b0;
            mac_valid  <= 1'b0;
            mac_last   <= 1'b0;
            act_req    <= 1'b0;
            upd_en     <= 1'b0;
            w_addr     <= '0;
        end else begin
            train_q    <= train_d;
            layer      <= layer_d;
            epoch_cnt  <= epoch_d;
            done_train <= done_train_d;
            busy       <= busy_d;
            done       <= done_d;
            acc_clr    <= acc_clr_d;
            mac_valid  <= mac_valid_d;
            mac_last   <= mac_last_d;
            act_req    <= act_req_d;
            upd_en     <= upd_en_d;
            w_addr     <= w_addr_d;
        end
    end

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer: per-cycle vector table for inference plus
// hand-written runs for backpressure, delayed activation, training and reset abort.
module tb_ann_layer_sequencer;
    import ann_seq_pkg::*;

    logic        Clock = 1'b0;
    logic        Rst, Start, train, mac_ready, act_done, upd_ready;
    logic        busy, done, done_train, layer;
    logic        acc_clr, mac_valid, mac_last, act_req, res_wr, upd_en;
    logic [3:0]  state;
    logic [7:0]  w_addr;
    logic [4:0]  in_sel;
    logic [2:0]  neuron_idx;
    logic [9:0]  epoch_cnt;

    ann_layer_sequencer #(.EPOCHS(2), .EP_W(10)) dut (
        .Clock(Clock), .Rst(Rst), .Start(Start), .train(train),
        .mac_ready(mac_ready), .act_done(act_done), .upd_ready(upd_ready),
        .busy(busy), .done(done), .done_train(done_train), .state(state),
        .w_addr(w_addr), .in_sel(in_sel), .layer(layer), .neuron_idx(neuron_idx),
        .acc_clr(acc_clr), .mac_valid(mac_valid), .mac_last(mac_last),
        .act_req(act_req), .res_wr(res_wr), .upd_en(upd_en), .epoch_cnt(epoch_cnt)
    );

    always #5 Clock = ~Clock;

    // flg = {busy, done, acc_clr, mac_valid, mac_last, act_req, res_wr}
    typedef struct {
        int         cyc;
        state_t     st;
        int         addr;
        int         isel;
        logic       lay;
        int         nidx;
        logic [6:0] flg;
    } vec_t;

    vec_t   tab[$];
    int     vectors, miscompares;
    int     done_cyc, done_pulses, upd_cnt, res_bad, stall_bad;
    int     mac_log[$], upd_log[$], last_log[$], res_lay[$], res_n[$], res_run[$];
    int     ep_log[$], dt_log[$];
    state_t st_log[$];
    int     exp_last[8] = '{29, 59, 89, 119, 149, 154, 159, 164};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v);
        check($sformatf("c%0d state", v.cyc), 32'(state), 32'(v.st));
        check($sformatf("c%0d w_addr", v.cyc), 32'(w_addr), v.addr);
        check($sformatf("c%0d in_sel", v.cyc), 32'(in_sel), v.isel);
        check($sformatf("c%0d layer", v.cyc), 32'(layer), 32'(v.lay));
        check($sformatf("c%0d neuron_idx", v.cyc), 32'(neuron_idx), v.nidx);
        check($sformatf("c%0d flags", v.cyc),
              32'({busy, done, acc_clr, mac_valid, mac_last, act_req, res_wr}), 32'(v.flg));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " state"}, 32'(state), 32'(IDLE));
        check({tag, " strobes"}, 32'({busy, done, done_train, acc_clr, mac_valid, mac_last,
                                      act_req, res_wr, upd_en, layer}), 0);
        check({tag, " indices"}, 32'({w_addr, in_sel, neuron_idx}), 0);
        check({tag, " epoch_cnt"}, 32'(epoch_cnt), 0);
    endtask

    function automatic int modseq_bad(input int q[$], input int n_exp);
        int bad = (q.size() != n_exp) ? 1 : 0;
        foreach (q[i]) if (q[i] != i % 165) bad++;
        return bad;
    endfunction

    function automatic int res_order_bad(input int lq[$], input int nq[$]);
        int bad = 0;
        foreach (lq[i]) begin
            if (lq[i] != ((i % 8) >= 5 ? 1 : 0)) bad++;
            if (nq[i] != ((i % 8) >= 5 ? (i % 8) - 5 : (i % 8))) bad++;
        end
        return bad;
    endfunction

    function automatic int last_bad(input int q[$]);
        int bad = (q.size() != 8) ? 1 : 0;
        foreach (q[i]) if (i < 8 && q[i] != exp_last[i]) bad++;
        return bad;
    endfunction

    // Start is raised in cycle 0 (the caller's current cycle); cycle c begins at the c-th edge after.
    task automatic run(input logic tr, input bit bp, input int act_delay, input int rst_at,
                       input int hold_lo, input int hold_hi, input bit use_tab, input int max_cyc);
        int         act_run = 0;
        logic       pv_valid = 1'b0, pv_ready = 1'b0;
        logic [7:0] pv_addr = '0;
        logic [4:0] pv_sel = '0;
        done_cyc = -1; done_pulses = 0; upd_cnt = 0; res_bad = 0; stall_bad = 0;
        mac_log.delete(); upd_log.delete(); last_log.delete();
        res_lay.delete(); res_n.delete(); res_run.delete();
        ep_log.delete(); dt_log.delete(); st_log.delete();
        ep_log.push_back(int'(epoch_cnt));
        dt_log.push_back(int'(done_train));
        st_log.push_back(state_t'(state));
        Start = 1'b1;
        train = tr;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge Clock); #1;
            Start     = (c >= hold_lo && c <= hold_hi);
            train     = ~tr;
            Rst       = (c == rst_at);
            mac_ready = bp ? ((c % 2) == 1) : 1'b1;
            upd_ready = 1'b1;
            act_run   = act_req ? act_run + 1 : 0;
            act_done  = act_req && (act_run >= act_delay);
            #1;
            ep_log.push_back(int'(epoch_cnt));
            dt_log.push_back(int'(done_train));
            st_log.push_back(state_t'(state));
            if (pv_valid && !pv_ready && mac_valid && (w_addr !== pv_addr || in_sel !== pv_sel))
                stall_bad++;
            pv_valid = mac_valid; pv_ready = mac_ready; pv_addr = w_addr; pv_sel = in_sel;
            if (mac_valid && mac_ready) begin
                mac_log.push_back(int'(w_addr));
                if (mac_last) last_log.push_back(int'(w_addr));
            end
            if (upd_en) upd_cnt++;
            if (upd_en && upd_ready) upd_log.push_back(int'(w_addr));
            if (res_wr) begin
                res_lay.push_back(int'(layer));
                res_n.push_back(int'(neuron_idx));
                res_run.push_back(act_run);
                if (!act_done) res_bad++;
            end
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (use_tab) foreach (tab[i]) if (tab[i].cyc == c) apply_vec(tab[i]);
            if (done_cyc >= 0 && c > done_cyc) break;
        end
        Start = 1'b0; Rst = 1'b0; act_done = 1'b0;
    endtask

    initial begin
        int bad;
        vectors = 0; miscompares = 0;
        Rst = 1'b1; Start = 1'b0; train = 1'b0;
        mac_ready = 1'b1; act_done = 1'b0; upd_ready = 1'b1;

        tab.push_back('{1,   CLR,  0,   0,  1'b0, 0, 7'b1010000});
        tab.push_back('{2,   MAC,  0,   0,  1'b0, 0, 7'b1001000});
        tab.push_back('{3,   MAC,  1,   1,  1'b0, 0, 7'b1001000});
        tab.push_back('{31,  MAC,  29,  29, 1'b0, 0, 7'b1001100});
        tab.push_back('{32,  ACT,  0,   29, 1'b0, 0, 7'b1000011});
        tab.push_back('{33,  CLR,  0,   0,  1'b0, 1, 7'b1010000});
        tab.push_back('{34,  MAC,  30,  0,  1'b0, 1, 7'b1001000});
        tab.push_back('{160, ACT,  0,   29, 1'b0, 4, 7'b1000011});
        tab.push_back('{161, CLR,  0,   0,  1'b1, 0, 7'b1010000});
        tab.push_back('{162, MAC,  150, 0,  1'b1, 0, 7'b1001000});
        tab.push_back('{166, MAC,  154, 4,  1'b1, 0, 7'b1001100});
        tab.push_back('{167, ACT,  0,   4,  1'b1, 0, 7'b1000011});
        tab.push_back('{169, MAC,  155, 0,  1'b1, 1, 7'b1001000});
        tab.push_back('{181, ACT,  0,   4,  1'b1, 2, 7'b1000011});
        tab.push_back('{182, DONE, 0,   0,  1'b0, 0, 7'b1100000});
        tab.push_back('{183, IDLE, 0,   0,  1'b0, 0, 7'b0000000});

        repeat (3) @(posedge Clock);
        #1;
        check_idle("reset");
        Start = 1'b1;
        @(posedge Clock); #1;
        check_idle("rst+start");
        Rst = 1'b0; Start = 1'b0;
        @(posedge Clock); #1;
        check_idle("post-rst");

        // Training, two epochs, all ready.
        run(1'b1, 1'b0, 1, -1, 0, -1, 1'b0, 800);
        check("train done cycle", done_cyc, 693);
        check("train done pulses", done_pulses, 1);
        check("train upd_en cycles", upd_cnt, 330);
        check("train upd addr seq", modseq_bad(upd_log, 330), 0);
        check("train mac addr seq", modseq_bad(mac_log, 330), 0);
        check("train res_wr count", res_lay.size(), 16);
        check("train res_wr order", res_order_bad(res_lay, res_n), 0);
        check("epoch_cnt c346", ep_log[346], 0);
        check("epoch_cnt c347", ep_log[347], 1);
        check("done_train c692", dt_log[692], 0);
        check("done_train c693", dt_log[693], 1);
        repeat (3) @(posedge Clock);
        #1;
        check("done_train sticky", 32'(done_train), 1);
        check("epoch_cnt held", 32'(epoch_cnt), 1);

        // Inference with table checks; Start held high mid-run, train toggled.
        run(1'b0, 1'b0, 1, -1, 5, 40, 1'b1, 300);
        check("inf done_train before", dt_log[0], 1);
        check("inf done_train cleared", dt_log[1], 0);
        check("inf done cycle", done_cyc, 182);
        check("inf done pulses", done_pulses, 1);
        check("inf res_wr count", res_lay.size(), 8);
        check("inf res_wr order", res_order_bad(res_lay, res_n), 0);
        check("inf mac addr seq", modseq_bad(mac_log, 165), 0);
        check("inf mac_last addrs", last_bad(last_log), 0);
        check("inf upd_en never", upd_cnt, 0);

        // MAC backpressure: mac_ready high on odd cycles only.
        run(1'b0, 1'b1, 1, -1, 0, -1, 1'b0, 600);
        check("bp done cycle", done_cyc, 347);
        check("bp stall hold", stall_bad, 0);
        check("bp mac addr seq", modseq_bad(mac_log, 165), 0);
        check("bp mac_last addrs", last_bad(last_log), 0);
        check("bp res_wr order", res_order_bad(res_lay, res_n), 0);

        // act_done arrives in the 5th act_req cycle.
        run(1'b0, 1'b0, 5, -1, 0, -1, 1'b0, 400);
        check("actdly done cycle", done_cyc, 214);
        check("actdly res_wr count", res_lay.size(), 8);
        check("actdly res_wr with act_done", res_bad, 0);
        bad = 0;
        foreach (res_run[i]) if (res_run[i] != 5) bad++;
        check("actdly act_req length", bad, 0);

        // Reset during the update sweep of epoch 1.
        run(1'b1, 1'b0, 1, 600, 0, -1, 1'b0, 700);
        check("rst pre state", 32'(st_log[600]), 32'(UPD));
        check("rst pre epoch", ep_log[600], 1);
        check("rst post state", 32'(st_log[601]), 32'(IDLE));
        check("rst post epoch", ep_log[601], 0);
        check("rst post done_train", dt_log[601], 0);
        check("rst no done", done_pulses, 0);
        check("rst stays idle", 32'(st_log[700]), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
